// File: rtl/ccff_chain_loader.sv
// Byte-stream to configuration-chain loader, MSB-first, with gated shift enable.
// Define CCFF_READBACK_EN to add a CRC-checked circular readback (VERIFY) pass.
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 28,
    parameter int DATA_W    = 8,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              prog_clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int WC_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CHAIN_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        VERIFY,
        DONE
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  bit_cnt;
    logic [WC_W-1:0]   wleft;
    logic              head_q;

    // Bits of the word being latched that actually reach the chain.
    logic [CNT_W-1:0]  rem;
    logic [WC_W-1:0]   take;

    assign rem = CNT_W'(CHAIN_LEN) - bit_cnt;

    always_comb begin
        take = WC_W'(DATA_W);
        if (int'(rem) < DATA_W)
            take = WC_W'(rem);
    end

`ifdef CCFF_READBACK_EN
    logic [7:0]       crc_load;
    logic [7:0]       crc_tail;
    logic [7:0]       crc_tail_nxt;
    logic [CNT_W-1:0] vcnt;
    logic             err_q;

    function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
        logic fb;
        fb = c[7] ^ b;
        return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
    endfunction

    assign crc_tail_nxt = crc8_step(crc_tail, ccff_tail);
    assign ccff_head    = (state == VERIFY) ? ccff_tail : head_q;
    assign err          = err_q;
`else
    logic unused_tail;

    assign unused_tail = ccff_tail;
    assign ccff_head   = head_q;
    assign err         = 1'b0;
`endif

    always_ff @(posedge prog_clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            shreg         <= '0;
            bit_cnt       <= '0;
            wleft         <= '0;
            head_q        <= 1'b0;
            s_ready       <= 1'b0;
            ccff_shift_en <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
`ifdef CCFF_READBACK_EN
            crc_load      <= '0;
            crc_tail      <= '0;
            vcnt          <= '0;
            err_q         <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state   <= LOAD;
                        s_ready <= 1'b1;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                        bit_cnt <= '0;
`ifdef CCFF_READBACK_EN
                        crc_load <= '0;
                        crc_tail <= '0;
                        err_q    <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    if (s_valid && s_ready) begin
                        shreg         <= s_data << 1;
                        head_q        <= s_data[DATA_W-1];
                        wleft         <= take;
                        s_ready       <= 1'b0;
                        ccff_shift_en <= 1'b1;
                        state         <= SHIFT;
                    end
                end
                SHIFT: begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    wleft   <= wleft - WC_W'(1);
                    shreg   <= shreg << 1;
                    head_q  <= shreg[DATA_W-1];
`ifdef CCFF_READBACK_EN
                    crc_load <= crc8_step(crc_load, head_q);
`endif
                    if (bit_cnt == LAST) begin
                        head_q <= 1'b0;
`ifdef CCFF_READBACK_EN
                        // Enable stays high: rotation starts next cycle.
                        state <= VERIFY;
                        vcnt  <= '0;
`else
                        state         <= DONE;
                        ccff_shift_en <= 1'b0;
                        busy          <= 1'b0;
                        done          <= 1'b1;
`endif
                    end else if (wleft == WC_W'(1)) begin
                        state         <= LOAD;
                        s_ready       <= 1'b1;
                        ccff_shift_en <= 1'b0;
                        head_q        <= 1'b0;
                    end
                end
`ifdef CCFF_READBACK_EN
                VERIFY: begin
                    crc_tail <= crc_tail_nxt;
                    vcnt     <= vcnt + CNT_W'(1);
                    if (vcnt == LAST) begin
                        state         <= DONE;
                        ccff_shift_en <= 1'b0;
                        busy          <= 1'b0;
                        done          <= 1'b1;
                        err_q         <= (crc_load != crc_tail_nxt);
                    end
                end
`endif
                default: begin
                    state         <= IDLE;
                    s_ready       <= 1'b0;
                    ccff_shift_en <= 1'b0;
                    head_q        <= 1'b0;
                    busy          <= 1'b0;
                    done          <= 1'b0;
                end
            endcase
        end
    end

endmodule
